rf_write_arbiter: RTL and testbench

//  Shares the single register-file write port (Wen/WAddr/WData) between NREQ writers:

---
 rtl/rf_write_arbiter.sv | 134 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ writers,
// with a registered output stage and a sequenced clear of registers 1..2^AW-1.
module rf_write_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 4,
    parameter int DW   = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      Req,
    input  logic [NREQ*AW-1:0]   ReqAddr,
    input  logic [NREQ*DW-1:0]   ReqData,
    output logic [NREQ-1:0]      Grant,
    input  logic                 Clear,
    output logic                 ClrDone,
    output logic                 Busy,
    output logic                 Wen,
    output logic [AW-1:0]        WAddr,
    output logic [DW-1:0]        WData
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [RW-1:0]   rr_ptr;
    logic [RW-1:0]   rr_next;
    logic [AW-1:0]   clr_cnt;
    logic            last_clr;
    logic            gnt_valid;
    logic [RW-1:0]   gnt_idx;
    logic [RW-1:0]   cand_idx;
    int              cand;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    assign last_clr = (clr_cnt == '1);

    // Search starts at the rr pointer and wraps; arbitration only happens in IDLE out of reset.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        Grant     = '0;
        if (Reset && state == IDLE) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = int'(rr_ptr) + k;
                if (cand >= NREQ) begin
                    cand = cand - NREQ;
                end
                cand_idx = RW'(cand);
                if (!gnt_valid && Req[cand_idx]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand_idx;
                end
            end
            if (gnt_valid) begin
                Grant[gnt_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == RW'(k)) begin
                sel_addr = ReqAddr[k*AW +: AW];
                sel_data = ReqData[k*DW +: DW];
            end
        end
        rr_next = (gnt_idx == RW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        state_next = state;
        Busy       = (state == CLEAR);
        case (state)
            IDLE:    if (Clear)    state_next = CLEAR;
            CLEAR:   if (last_clr) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A grant on the same edge that Clear is taken still lands, ahead of the clear walk.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rr_ptr  <= '0;
            clr_cnt <= '0;
            Wen     <= 1'b0;
            WAddr   <= '0;
            WData   <= '0;
            ClrDone <= 1'b0;
        end else begin
            Wen     <= 1'b0;
            ClrDone <= 1'b0;
            if (state == CLEAR) begin
                Wen   <= 1'b1;
                WAddr <= clr_cnt;
                WData <= '0;
                if (last_clr) begin
                    ClrDone <= 1'b1;
                    clr_cnt <= '0;
                end else begin
                    clr_cnt <= clr_cnt + 1'b1;
                end
            end else begin
                if (gnt_valid) begin
                    Wen    <= (sel_addr != '0);
                    WAddr  <= sel_addr;
                    WData  <= sel_data;
                    rr_ptr <= rr_next;
                end
                if (Clear) begin
                    clr_cnt <= AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (NREQ=2, AW=4, DW=16).
module tb_rf_write_arbiter;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [1:0]  Req = '0;
    logic [7:0]  ReqAddr = '0;
    logic [31:0] ReqData = '0;
    logic [1:0]  Grant;
    logic        Clear = 1'b0;
    logic        ClrDone;
    logic        Busy;
    logic        Wen;
    logic [3:0]  WAddr;
    logic [15:0] WData;

    int passed = 0;
    int total  = 0;

    rf_write_arbiter #(.NREQ(2), .AW(4), .DW(16)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .Grant(Grant), .Clear(Clear), .ClrDone(ClrDone), .Busy(Busy),
        .Wen(Wen), .WAddr(WAddr), .WData(WData)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0; Req = '0; Clear = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Req = '0; Clear = 1'b0;
        tick(); tick();
        total++; if (Grant !== 2'b00) $display("[TB] FAIL reset_grant: got %b want 00", Grant); else passed++;
        total++; if (Wen !== 1'b0) $display("[TB] FAIL reset_wen: got %b want 0", Wen); else passed++;
        total++; if (WAddr !== 4'd0) $display("[TB] FAIL reset_waddr: got %0d want 0", WAddr); else passed++;
        total++; if (WData !== 16'h0) $display("[TB] FAIL reset_wdata: got %h want 0000", WData); else passed++;
        total++; if (Busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", Busy); else passed++;
        total++; if (ClrDone !== 1'b0) $display("[TB] FAIL reset_clrdone: got %b want 0", ClrDone); else passed++;
        Req = 2'b01;
        #1;
        total++; if (Grant !== 2'b00) $display("[TB] FAIL reset_grant_held: got %b want 00", Grant); else passed++;
        Req = 2'b00;
        Reset = 1'b1;
        #1;
    endtask

    task automatic test_single();
        ReqAddr[3:0] = 4'd3; ReqData[15:0] = 16'hABCD; Req = 2'b01;
        #1;
        total++; if (Grant !== 2'b01) $display("[TB] FAIL single_grant: got %b want 01", Grant); else passed++;
        tick();
        Req = 2'b00;
        total++; if (Wen !== 1'b1) $display("[TB] FAIL single_wen: got %b want 1", Wen); else passed++;
        total++; if (WAddr !== 4'd3) $display("[TB] FAIL single_waddr: got %0d want 3", WAddr); else passed++;
        total++; if (WData !== 16'hABCD) $display("[TB] FAIL single_wdata: got %h want abcd", WData); else passed++;
        tick();
        total++; if (Wen !== 1'b0) $display("[TB] FAIL single_wen_off: got %b want 0", Wen); else passed++;
        total++; if (WAddr !== 4'd3) $display("[TB] FAIL single_waddr_hold: got %0d want 3", WAddr); else passed++;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [3:0]  exp_a;
        logic [15:0] exp_d;
        do_reset();
        ReqAddr = {4'd6, 4'd5}; ReqData = {16'h2222, 16'h1111}; Req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (i % 2 == 0) ? 4'd5 : 4'd6;
            exp_d = (i % 2 == 0) ? 16'h1111 : 16'h2222;
            #1;
            total++; if (Grant !== exp_g) $display("[TB] FAIL rr_grant%0d: got %b want %b", i, Grant, exp_g); else passed++;
            tick();
            total++; if (Wen !== 1'b1 || WAddr !== exp_a || WData !== exp_d)
                $display("[TB] FAIL rr_write%0d: got wen=%b addr=%0d data=%h want 1/%0d/%h", i, Wen, WAddr, WData, exp_a, exp_d);
            else passed++;
        end
        Req = 2'b00;
        tick();
    endtask

    task automatic test_addr_zero();
        ReqAddr = {4'd9, 4'd0}; ReqData = {16'h5A5A, 16'hBEEF}; Req = 2'b01;
        #1;
        total++; if (Grant !== 2'b01) $display("[TB] FAIL zero_grant: got %b want 01", Grant); else passed++;
        tick();
        Req = 2'b00;
        total++; if (Wen !== 1'b0) $display("[TB] FAIL zero_wen: got %b want 0", Wen); else passed++;
        Req = 2'b11;
        #1;
        total++; if (Grant !== 2'b10) $display("[TB] FAIL zero_rr_advance: got %b want 10", Grant); else passed++;
        tick();
        Req = 2'b00;
        total++; if (Wen !== 1'b1 || WAddr !== 4'd9 || WData !== 16'h5A5A)
            $display("[TB] FAIL zero_next_write: got wen=%b addr=%0d data=%h want 1/9/5a5a", Wen, WAddr, WData);
        else passed++;
        tick();
    endtask

    task automatic test_clear();
        ReqAddr = {4'd8, 4'd7}; ReqData = {16'h8888, 16'h7777}; Req = 2'b11; Clear = 1'b1;
        #1;
        total++; if (Grant !== 2'b01) $display("[TB] FAIL clear_same_grant: got %b want 01", Grant); else passed++;
        tick();
        Clear = 1'b0;
        total++; if (Wen !== 1'b1 || WAddr !== 4'd7 || WData !== 16'h7777)
            $display("[TB] FAIL clear_pre_write: got wen=%b addr=%0d data=%h want 1/7/7777", Wen, WAddr, WData);
        else passed++;
        for (int c = 1; c <= 15; c++) begin
            Clear = (c == 3);
            #1;
            total++; if (Grant !== 2'b00 || Busy !== 1'b1)
                $display("[TB] FAIL clear_busy%0d: got grant=%b busy=%b want 00/1", c, Grant, Busy);
            else passed++;
            tick();
            total++; if (Wen !== 1'b1 || WAddr !== 4'(c) || WData !== 16'h0 || ClrDone !== (c == 15))
                $display("[TB] FAIL clear_walk%0d: got wen=%b addr=%0d data=%h done=%b want 1/%0d/0000/%b",
                         c, Wen, WAddr, WData, ClrDone, c, (c == 15));
            else passed++;
        end
        Clear = 1'b0;
        #1;
        total++; if (Busy !== 1'b0 || Grant !== 2'b10)
            $display("[TB] FAIL clear_resume: got busy=%b grant=%b want 0/10", Busy, Grant);
        else passed++;
        tick();
        Req = 2'b00;
        total++; if (Wen !== 1'b1 || WAddr !== 4'd8 || ClrDone !== 1'b0)
            $display("[TB] FAIL clear_resume_write: got wen=%b addr=%0d done=%b want 1/8/0", Wen, WAddr, ClrDone);
        else passed++;
        tick();
    endtask

    task automatic test_clear_reset();
        int seen_done;
        seen_done = 0;
        Req = 2'b00; Clear = 1'b1;
        tick();
        Clear = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        total++; if (Busy !== 1'b1 || WAddr !== 4'd6)
            $display("[TB] FAIL abort_midwalk: got busy=%b addr=%0d want 1/6", Busy, WAddr);
        else passed++;
        Reset = 1'b0;
        tick();
        total++; if (Wen !== 1'b0 || Busy !== 1'b0 || ClrDone !== 1'b0)
            $display("[TB] FAIL abort_state: got wen=%b busy=%b done=%b want 0/0/0", Wen, Busy, ClrDone);
        else passed++;
        Reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ClrDone !== 1'b0 || Wen !== 1'b0) seen_done++;
        end
        total++; if (seen_done !== 0) $display("[TB] FAIL abort_no_done: got %0d stray cycles want 0", seen_done); else passed++;
        Req = 2'b11;
        #1;
        total++; if (Grant !== 2'b01) $display("[TB] FAIL abort_rr_reset: got %b want 01", Grant); else passed++;
        Req = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_addr_zero();
        test_clear();
        test_clear_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
